// File: rtl/gb_cart_pkg.sv
// Shared cartridge definitions: responder FSM states, console address
// regions, the external-RAM enable key and the access record type.
package gb_cart_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mbc_state_e;

    // Console address regions
    localparam logic [15:0] ROM0_END       = 16'h3FFF;
    localparam logic [15:0] ROMX_BASE      = 16'h4000;
    localparam logic [15:0] ROMX_END       = 16'h7FFF;
    localparam logic [15:0] REG_BANK1_BASE = 16'h2000;
    localparam logic [15:0] REG_BANK2_BASE = 16'h4000;
    localparam logic [15:0] REG_MODE_BASE  = 16'h6000;
    localparam logic [15:0] ERAM_BASE      = 16'hA000;
    localparam logic [15:0] ERAM_END       = 16'hBFFF;

    // Low nibble written to the RAM-enable register that opens external RAM
    localparam logic [3:0]  RAM_EN_KEY     = 4'hA;

    // One console access waiting to be (or being) issued to the backing store
    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } cart_acc_t;

    function automatic logic is_rom(input logic [15:0] a);
        return (a <= ROMX_END);
    endfunction

    function automatic logic is_romx(input logic [15:0] a);
        return (a >= ROMX_BASE) && (a > ROM0_END);
    endfunction

    function automatic logic is_eram(input logic [15:0] a);
        return (a >= ERAM_BASE) && (a <= ERAM_END);
    endfunction

endpackage

// File: rtl/mbc1_bank_regs.sv
// MBC1 bank/mode registers and the console-to-backing-store address map.
// External RAM enable register exists only when MBC1_EXT_RAM_EN is defined.
module mbc1_bank_regs
    import gb_cart_pkg::*;
#(
    parameter int ROM_BANKS = 128,
    parameter int RAM_BANKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [15:0] reg_addr,
    input  logic [4:0]  reg_wdata,
    input  logic [15:0] map_addr,
    output logic [21:0] map_mem_addr
`ifdef MBC1_EXT_RAM_EN
    ,
    output logic        ram_en
`endif
);

    localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);
    localparam logic [1:0] RAM_MASK = 2'(RAM_BANKS - 1);

    logic [4:0] bank1_r;
    logic [1:0] bank2_r;
    logic       mode_r;
    logic [6:0] rom_bank_s;
    logic [1:0] ram_bank_s;

    // Bank and mode registers; a bank1 value of 0 is promoted to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank1_r <= 5'd1;
            bank2_r <= 2'd0;
            mode_r  <= 1'b0;
        end else if (reg_we) begin
            if (reg_addr >= REG_MODE_BASE) begin
                mode_r <= reg_wdata[0];
            end else if (reg_addr >= REG_BANK2_BASE) begin
                bank2_r <= reg_wdata[1:0];
            end else if (reg_addr >= REG_BANK1_BASE) begin
                bank1_r <= (reg_wdata == 5'd0) ? 5'd1 : reg_wdata;
            end else begin
                bank1_r <= bank1_r;
            end
        end else begin
            bank1_r <= bank1_r;
        end
    end

`ifdef MBC1_EXT_RAM_EN
    logic ram_en_r;

    // External RAM opens only for the exact enable key in the low nibble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en_r <= 1'b0;
        end else if (reg_we && (reg_addr < REG_BANK1_BASE)) begin
            ram_en_r <= (reg_wdata[3:0] == RAM_EN_KEY);
        end else begin
            ram_en_r <= ram_en_r;
        end
    end

    assign ram_en = ram_en_r;
`endif

    // Translate a console address into a ROM or RAM backing-store address
    always_comb begin
        rom_bank_s   = 7'd0;
        ram_bank_s   = 2'd0;
        map_mem_addr = 22'h000000;
        if (is_romx(map_addr)) begin
            rom_bank_s = {bank2_r, bank1_r} & ROM_MASK;
        end else if (mode_r) begin
            rom_bank_s = {bank2_r, 5'b00000} & ROM_MASK;
        end else begin
            rom_bank_s = 7'd0;
        end
        ram_bank_s = (mode_r ? bank2_r : 2'd0) & RAM_MASK;
        if (is_eram(map_addr)) begin
            map_mem_addr = {1'b1, 6'b000000, ram_bank_s, map_addr[12:0]};
        end else begin
            map_mem_addr = {1'b0, rom_bank_s, map_addr[13:0]};
        end
    end

endmodule

// File: rtl/mbc1_responder.sv
// MBC1 cartridge responder: turns console read/write strobes into register
// updates or single backing-store requests, with one pending slot.
// Optional external RAM path: define MBC1_EXT_RAM_EN.
module mbc1_responder
    import gb_cart_pkg::*;
#(
    parameter int ROM_BANKS = 128,
    parameter int RAM_BANKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] CART_ADDR,
    input  logic [7:0]  CART_DATA_in,
    output logic [7:0]  CART_DATA_out,
    input  logic        CART_RD,
    input  logic        CART_WR,
    output logic [21:0] MEM_ADDR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        OVERRUN
);

    logic        rd_prev_r, wr_prev_r;
    logic [15:0] last_rd_addr_r;
    logic        rd_evt_s, wr_evt_s, reg_we_s, acc_evt_s;
    cart_acc_t   evt_acc_s, src_acc_s;
    logic        src_valid_s;
    cart_acc_t   pend_acc_r, pend_acc_nxt_s;
    logic        pend_valid_r, pend_valid_nxt_s;
    mbc_state_e  state_r, state_nxt_s;
    logic        mem_req_r, mem_req_nxt_s;
    logic        mem_we_r, mem_we_nxt_s;
    logic [21:0] mem_addr_r, mem_addr_nxt_s;
    logic [7:0]  mem_wdata_r, mem_wdata_nxt_s;
    logic [7:0]  data_out_r, data_out_nxt_s;
    logic        overrun_r, overrun_nxt_s;
    logic [21:0] map_addr_s;
    logic        ram_ok_s;

    mbc1_bank_regs #(
        .ROM_BANKS (ROM_BANKS),
        .RAM_BANKS (RAM_BANKS)
    ) u_bank_regs (
        .clk          (clk),
        .rst          (rst),
        .reg_we       (reg_we_s),
        .reg_addr     (CART_ADDR),
        .reg_wdata    (CART_DATA_in[4:0]),
        .map_addr     (src_acc_s.addr),
        .map_mem_addr (map_addr_s)
`ifdef MBC1_EXT_RAM_EN
        ,
        .ram_en       (ram_ok_s)
`endif
    );

`ifndef MBC1_EXT_RAM_EN
    // Without the RAM path every RAM access behaves as if RAM were disabled
    assign ram_ok_s = 1'b0;
`endif

    // Detect read/write events and classify them as register or memory access
    always_comb begin
        rd_evt_s  = CART_RD && (!rd_prev_r || (CART_ADDR != last_rd_addr_r));
        wr_evt_s  = CART_WR && !wr_prev_r;
        reg_we_s  = wr_evt_s && is_rom(CART_ADDR);
        acc_evt_s = 1'b0;
        if (wr_evt_s) begin
            acc_evt_s = is_eram(CART_ADDR);
        end else if (rd_evt_s) begin
            acc_evt_s = is_rom(CART_ADDR) || is_eram(CART_ADDR);
        end else begin
            acc_evt_s = 1'b0;
        end
        evt_acc_s.addr  = CART_ADDR;
        evt_acc_s.we    = wr_evt_s;
        evt_acc_s.wdata = CART_DATA_in;
        src_acc_s   = pend_valid_r ? pend_acc_r : evt_acc_s;
        src_valid_s = pend_valid_r || acc_evt_s;
    end

    // Strobe history and last read address for event detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_prev_r      <= 1'b0;
            wr_prev_r      <= 1'b0;
            last_rd_addr_r <= 16'h0000;
        end else begin
            rd_prev_r <= CART_RD;
            wr_prev_r <= CART_WR;
            if (rd_evt_s) begin
                last_rd_addr_r <= CART_ADDR;
            end else begin
                last_rd_addr_r <= last_rd_addr_r;
            end
        end
    end

    // Next-state and output logic; the pending slot is served before new events
    always_comb begin
        state_nxt_s      = state_r;
        pend_acc_nxt_s   = pend_acc_r;
        pend_valid_nxt_s = pend_valid_r;
        mem_req_nxt_s    = mem_req_r;
        mem_we_nxt_s     = mem_we_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        data_out_nxt_s   = data_out_r;
        overrun_nxt_s    = overrun_r;
        case (state_r)
            ST_IDLE: begin
                // a new event takes the slot the pending access is leaving
                if (pend_valid_r && acc_evt_s) begin
                    pend_acc_nxt_s   = evt_acc_s;
                    pend_valid_nxt_s = 1'b1;
                end else begin
                    pend_valid_nxt_s = 1'b0;
                end
                if (src_valid_s) begin
                    if (is_eram(src_acc_s.addr) && !ram_ok_s) begin
                        if (src_acc_s.we) begin
                            data_out_nxt_s = data_out_r;
                        end else begin
                            data_out_nxt_s = 8'hFF;
                        end
                    end else begin
                        state_nxt_s     = ST_REQ;
                        mem_req_nxt_s   = 1'b1;
                        mem_we_nxt_s    = src_acc_s.we;
                        mem_addr_nxt_s  = map_addr_s;
                        mem_wdata_nxt_s = src_acc_s.we ? src_acc_s.wdata : 8'h00;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (MEM_ACK) begin
                    state_nxt_s   = ST_IDLE;
                    mem_req_nxt_s = 1'b0;
                    mem_we_nxt_s  = 1'b0;
                    if (mem_we_r) begin
                        data_out_nxt_s = data_out_r;
                    end else begin
                        data_out_nxt_s = MEM_RDATA;
                    end
                end else begin
                    state_nxt_s = ST_REQ;
                end
                if (acc_evt_s) begin
                    if (pend_valid_r) begin
                        overrun_nxt_s = 1'b1;
                    end else begin
                        pend_acc_nxt_s   = evt_acc_s;
                        pend_valid_nxt_s = 1'b1;
                    end
                end else begin
                    pend_valid_nxt_s = pend_valid_r;
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                mem_req_nxt_s    = 1'b0;
                mem_we_nxt_s     = 1'b0;
                pend_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, pending slot and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pend_acc_r   <= '{addr: 16'h0000, we: 1'b0, wdata: 8'h00};
            pend_valid_r <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 22'h000000;
            mem_wdata_r  <= 8'h00;
            data_out_r   <= 8'hFF;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pend_acc_r   <= pend_acc_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            data_out_r   <= data_out_nxt_s;
            overrun_r    <= overrun_nxt_s;
        end
    end

    assign CART_DATA_out = data_out_r;
    assign MEM_REQ       = mem_req_r;
    assign MEM_WE        = mem_we_r;
    assign MEM_ADDR      = mem_addr_r;
    assign MEM_WDATA     = mem_wdata_r;
    assign OVERRUN       = overrun_r;

endmodule

// File: tb/tb_mbc1_responder.sv
// Self-checking bench for mbc1_responder: vector table plus hand sequences,
// backing-store requests checked against a scoreboard queue.
module tb_mbc1_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] CART_ADDR = 16'h0000;
    logic [7:0]  CART_DATA_in = 8'h00;
    logic [7:0]  CART_DATA_out;
    logic        CART_RD = 1'b0;
    logic        CART_WR = 1'b0;
    logic [21:0] MEM_ADDR;
    logic        MEM_REQ, MEM_WE;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA = 8'h00;
    logic        MEM_ACK = 1'b0;
    logic        OVERRUN;

    always #5 clk = ~clk;

    mbc1_responder #(.ROM_BANKS(128), .RAM_BANKS(4)) dut (
        .clk(clk), .rst(rst), .CART_ADDR(CART_ADDR), .CART_DATA_in(CART_DATA_in),
        .CART_DATA_out(CART_DATA_out), .CART_RD(CART_RD), .CART_WR(CART_WR),
        .MEM_ADDR(MEM_ADDR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .OVERRUN(OVERRUN)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [21:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        exp_req;
        logic [21:0] exp_addr;
        logic [7:0]  rd;
        logic [7:0]  exp_dout;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                                input logic er, input logic [21:0] ea, input logic [7:0] rd,
                                input logic [7:0] ed);
        vec_t v;
        v.wr = wr; v.addr = a; v.wd = wd; v.exp_req = er;
        v.exp_addr = ea; v.rd = rd; v.exp_dout = ed;
        vecs.push_back(v);
    endfunction

    task automatic push_exp(input logic [21:0] a, input logic we, input logic [7:0] wd);
        exp_t e;
        e.addr = a; e.we = we; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // one-cycle strobe, starting and ending on a falling edge
    task automatic drive_ev(input logic wr, input logic [15:0] a, input logic [7:0] d);
        CART_ADDR = a;
        CART_DATA_in = d;
        if (wr) CART_WR = 1'b1;
        else    CART_RD = 1'b1;
        @(negedge clk);
        CART_RD = 1'b0;
        CART_WR = 1'b0;
    endtask

    task automatic ack_access(input logic [7:0] rd, input logic [7:0] exp_dout, input string name);
        int n = 0;
        while (MEM_REQ !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req"}, 32'(MEM_REQ), 32'd1);
        MEM_RDATA = rd;
        MEM_ACK = 1'b1;
        @(negedge clk);
        MEM_ACK = 1'b0;
        check({name, "_dout"}, 32'(CART_DATA_out), 32'(exp_dout));
        check({name, "_req_drop"}, 32'(MEM_REQ), 32'd0);
    endtask

    // scoreboard: every rising MEM_REQ must match the oldest expected access
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (MEM_REQ === 1'b1 && req_prev !== 1'b1) begin
            check("req_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_addr", 32'(MEM_ADDR), 32'(e.addr));
                check("sb_we", 32'(MEM_WE), 32'(e.we));
                if (e.we) check("sb_wdata", 32'(MEM_WDATA), 32'(e.wdata));
            end
        end
        req_prev <= MEM_REQ;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(CART_DATA_out), 32'hFF);
        check("rst_req", 32'(MEM_REQ), 32'd0);
        check("rst_we", 32'(MEM_WE), 32'd0);
        check("rst_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_wdata", 32'(MEM_WDATA), 32'd0);
        check("rst_overrun", 32'(OVERRUN), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // wr, addr, wdata, exp_req, exp_mem_addr, rdata, exp_dout
        add(1'b0, 16'h4000, 8'h00, 1'b1, 22'h004000, 8'h3C, 8'h3C);
        add(1'b1, 16'h2000, 8'h00, 1'b0, 22'h000000, 8'h00, 8'h3C);
        add(1'b0, 16'h4123, 8'h00, 1'b1, 22'h004123, 8'hA7, 8'hA7);
        add(1'b1, 16'h4000, 8'h02, 1'b0, 22'h000000, 8'h00, 8'hA7);
        add(1'b1, 16'h6000, 8'h01, 1'b0, 22'h000000, 8'h00, 8'hA7);
        add(1'b0, 16'h0010, 8'h00, 1'b1, 22'h100010, 8'h11, 8'h11);
        add(1'b0, 16'h4123, 8'h00, 1'b1, 22'h104123, 8'h22, 8'h22);
        add(1'b0, 16'hA000, 8'h00, 1'b0, 22'h000000, 8'h00, 8'hFF);
        add(1'b1, 16'h0000, 8'h0A, 1'b0, 22'h000000, 8'h00, 8'hFF);
        add(1'b1, 16'h6000, 8'h00, 1'b0, 22'h000000, 8'h00, 8'hFF);
`ifdef MBC1_EXT_RAM_EN
        add(1'b1, 16'hA001, 8'h55, 1'b1, 22'h200001, 8'h00, 8'hFF);
        add(1'b0, 16'h7FFF, 8'h00, 1'b1, 22'h107FFF, 8'h99, 8'h99);
        add(1'b0, 16'hA001, 8'h00, 1'b1, 22'h200001, 8'h5A, 8'h5A);
`else
        add(1'b1, 16'hA001, 8'h55, 1'b0, 22'h000000, 8'h00, 8'hFF);
        add(1'b0, 16'h7FFF, 8'h00, 1'b1, 22'h107FFF, 8'h99, 8'h99);
        add(1'b0, 16'hA001, 8'h00, 1'b0, 22'h000000, 8'h00, 8'hFF);
`endif
        add(1'b1, 16'h2000, 8'h1F, 1'b0, 22'h000000, 8'h00, 8'h00);
        add(1'b0, 16'h4000, 8'h00, 1'b1, 22'h17C000, 8'h44, 8'h44);
        add(1'b0, 16'hC000, 8'h00, 1'b0, 22'h000000, 8'h00, 8'h44);
        add(1'b1, 16'h8000, 8'h33, 1'b0, 22'h000000, 8'h00, 8'h44);
        add(1'b1, 16'h6000, 8'h01, 1'b0, 22'h000000, 8'h00, 8'h44);
`ifdef MBC1_EXT_RAM_EN
        add(1'b0, 16'hA123, 8'h00, 1'b1, 22'h204123, 8'h6B, 8'h6B);
        add(1'b1, 16'h0000, 8'h00, 1'b0, 22'h000000, 8'h00, 8'h6B);
`else
        add(1'b0, 16'hA123, 8'h00, 1'b0, 22'h000000, 8'h00, 8'hFF);
        add(1'b1, 16'h0000, 8'h00, 1'b0, 22'h000000, 8'h00, 8'hFF);
`endif
        add(1'b0, 16'hA123, 8'h00, 1'b0, 22'h000000, 8'h00, 8'hFF);
        add(1'b0, 16'h0000, 8'h00, 1'b1, 22'h100000, 8'h0C, 8'h0C);
        // the bank1 write row reads back whatever the previous row left
        vecs[13].exp_dout = vecs[12].exp_dout;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            if (v.exp_req) push_exp(v.exp_addr, v.wr, v.wd);
            drive_ev(v.wr, v.addr, v.wd);
            if (v.exp_req) begin
                ack_access(v.rd, v.exp_dout, $sformatf("vec%0d", i));
            end else begin
                check($sformatf("vec%0d_noreq", i), 32'(MEM_REQ), 32'd0);
                check($sformatf("vec%0d_dout", i), 32'(CART_DATA_out), 32'(v.exp_dout));
                @(negedge clk);
            end
        end

        // pending slot, register write during REQ, overrun on third event
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_exp(22'h004000, 1'b0, 8'h00);
        drive_ev(1'b0, 16'h4000, 8'h00);
        drive_ev(1'b1, 16'h2000, 8'h03);
        push_exp(22'h00C000, 1'b0, 8'h00);
        CART_ADDR = 16'h4000;
        CART_RD = 1'b1;
        @(negedge clk);
        CART_ADDR = 16'h5000;
        @(negedge clk);
        CART_RD = 1'b0;
        check("ovr_flag", 32'(OVERRUN), 32'd1);
        check("ovr_addr_held", 32'(MEM_ADDR), 32'h004000);
        repeat (3) @(negedge clk);
        check("ovr_req_held", 32'(MEM_REQ), 32'd1);
        ack_access(8'h81, 8'h81, "ovr_first");
        ack_access(8'h82, 8'h82, "ovr_second");
        repeat (5) @(negedge clk);
        check("ovr_third_dropped", 32'(MEM_REQ), 32'd0);
        check("ovr_sticky", 32'(OVERRUN), 32'd1);

        // reset during REQ, then a late acknowledge
        push_exp(22'h00C000, 1'b0, 8'h00);
        drive_ev(1'b0, 16'h4000, 8'h00);
        check("mid_req_up", 32'(MEM_REQ), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(MEM_REQ), 32'd0);
        check("mid_rst_dout", 32'(CART_DATA_out), 32'hFF);
        check("mid_rst_overrun", 32'(OVERRUN), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        MEM_RDATA = 8'h77;
        MEM_ACK = 1'b1;
        @(negedge clk);
        MEM_ACK = 1'b0;
        @(negedge clk);
        check("late_ack_dout", 32'(CART_DATA_out), 32'hFF);
        check("late_ack_req", 32'(MEM_REQ), 32'd0);
        push_exp(22'h004000, 1'b0, 8'h00);
        drive_ev(1'b0, 16'h4000, 8'h00);
        ack_access(8'h5E, 8'h5E, "post_rst_bank1");

        // RD held high: same address is one event, an address change is another
        push_exp(22'h000005, 1'b0, 8'h00);
        CART_ADDR = 16'h0005;
        CART_RD = 1'b1;
        @(negedge clk);
        ack_access(8'h05, 8'h05, "hold_first");
        repeat (3) @(negedge clk);
        check("hold_no_repeat", 32'(MEM_REQ), 32'd0);
        push_exp(22'h000006, 1'b0, 8'h00);
        CART_ADDR = 16'h0006;
        @(negedge clk);
        ack_access(8'h06, 8'h06, "hold_addr_change");
        CART_RD = 1'b0;
        repeat (3) @(negedge clk);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
